// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
// FIFO_UART_TX_PARITY_EN adds an even-parity bit per byte.
package fifo_uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int BYTES_PER_WORD = 2;
   localparam int WORD_W = UART_DATA_BITS * BYTES_PER_WORD;
   localparam logic TX_IDLE = 1'b1;
   localparam int CLKS_PER_BIT_DEF = 434;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
      STOP   = 3'd5,
      PARITY = 3'd6
`else
      STOP   = 3'd5
`endif
   } state_t;

   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the FIFO (master) and its reader.
// The reader pulses fifo_rd_en; data is valid the cycle after.
interface fifo_uart_tx_if;
   import fifo_uart_pkg::*;

   logic              fifo_empty;
   logic [WORD_W-1:0] fifo_data;
   logic              fifo_rd_en;

   modport master (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );

   modport slave (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

endinterface

// File: rtl/uart_tx_byte.sv
// Serialises one byte as a UART frame (start, 8 data LSB-first, stop).
// FIFO_UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_tx_byte
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_i,
   output logic       tx,
   output logic       done
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             tx_q, tx_d;
   logic [2:0]       idx_nxt;
   logic             last;

   assign last    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign idx_nxt = idx_q + 3'd1;
   assign done    = (state_q == STOP) && last;
   assign tx      = tx_q;

   // Next-state: walk start/data/(parity)/stop, one bit per period.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = TX_IDLE;
            if (start) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               tx_d    = byte_i[0];
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  tx_d    = even_par(byte_i);
                  state_d = PARITY;
`else
                  tx_d    = TX_IDLE;
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_nxt;
                  tx_d  = byte_i[idx_nxt];
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               cnt_d   = '0;
               tx_d    = TX_IDLE;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               cnt_d = '0;
               if (start) begin
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = TX_IDLE;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            tx_d    = TX_IDLE;
            state_d = IDLE;
         end
      endcase
   end

   // Frame state and line register; reset forces the line high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         tx_q    <= TX_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops 16-bit words from a FIFO and sends them low byte first over UART.
// Build with FIFO_UART_TX_PARITY_EN for an even-parity bit per byte.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   fifo_uart_tx_if.slave  fifo,
   output logic           tx,
   output logic           busy,
   output logic           word_done
);

   state_t            state_q, state_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              word_done_q, word_done_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              byte_sel_q, byte_sel_d;
   logic              start;
   logic              byte_done;
   logic [7:0]        cur_byte;

   assign cur_byte        = byte_sel_q ? word_q[15:8] : word_q[7:0];
   assign fifo.fifo_rd_en = rd_en_q;
   assign busy            = busy_q;
   assign word_done       = word_done_q;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .byte_i (cur_byte),
      .tx     (tx),
      .done   (byte_done)
   );

   // Next-state: pop, wait out the FIFO latency, then chain two bytes.
   // START here means the byte engine owns the line.
   always_comb begin
      state_d     = state_q;
      rd_en_d     = 1'b0;
      busy_d      = busy_q;
      word_done_d = 1'b0;
      word_d      = word_q;
      byte_sel_d  = byte_sel_q;
      start       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable && !fifo.fifo_empty) begin
               rd_en_d = 1'b1;
               busy_d  = 1'b1;
               state_d = POP;
            end
         end
         POP: state_d = LOAD;
         LOAD: begin
            word_d     = fifo.fifo_data;
            byte_sel_d = 1'b0;
            start      = 1'b1;
            state_d    = START;
         end
         START: begin
            if (byte_done) begin
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  start      = 1'b1;
               end else begin
                  word_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Word-level state with registered strobe and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
         word_q      <= '0;
         byte_sel_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         word_done_q <= word_done_d;
         word_q      <= word_d;
         byte_sel_q  <= byte_sel_d;
      end
   end

endmodule
